// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA display controller.
package vga_pkg;

  localparam int unsigned DefHActive = 640;
  localparam int unsigned DefHFp     = 16;
  localparam int unsigned DefHSync   = 96;
  localparam int unsigned DefHBp     = 48;
  localparam int unsigned DefVActive = 480;
  localparam int unsigned DefVFp     = 10;
  localparam int unsigned DefVSync   = 2;
  localparam int unsigned DefVBp     = 33;
  localparam int unsigned DefCntW    = 10;
  localparam int unsigned DefColorW  = 3;
  localparam int unsigned DefRdLat   = 1;

  typedef logic [DefCntW-1:0]   coord_t;
  typedef logic [DefColorW-1:0] color_t;

  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
  } vga_flags_t;

  function automatic int unsigned vga_total(int unsigned act, int unsigned fp,
                                            int unsigned sync, int unsigned bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Parametrised shift register with synchronous reset; DEPTH=0 is a wire.
module vga_delay_line #(
  parameter int unsigned      WIDTH   = 1,
  parameter int unsigned      DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] d_o
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_i;
    assign d_o = d_i;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
      stage_d[0] = d_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          stage_q[i] <= RST_VAL;
        end
      end else begin
        stage_q <= stage_d;
      end
    end

    assign d_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_display_ctrl.sv
// VGA raster timing and pin-aligned pixel output with renderer latency compensation.
// Define VGA_TEST_PATTERN_EN to replace rgb_in with eight vertical colour bars.
module vga_display_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DefHActive,
  parameter int unsigned H_FP     = DefHFp,
  parameter int unsigned H_SYNC   = DefHSync,
  parameter int unsigned H_BP     = DefHBp,
  parameter int unsigned V_ACTIVE = DefVActive,
  parameter int unsigned V_FP     = DefVFp,
  parameter int unsigned V_SYNC   = DefVSync,
  parameter int unsigned V_BP     = DefVBp,
  parameter logic        SYNC_POL = 1'b1,
  parameter int unsigned COLOR_W  = DefColorW,
  parameter int unsigned CNT_W    = DefCntW,
  parameter int unsigned RD_LAT   = DefRdLat
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COLOR_W-1:0] rgb_in,
  output logic [CNT_W-1:0]   x_pos,
  output logic [CNT_W-1:0]   y_pos,
  output logic               active,
  output logic               frame_start,
  output logic               line_start,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [COLOR_W-1:0] color
);

  localparam int unsigned HTotal      = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned VTotal      = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam logic [CNT_W-1:0] HLast  = CNT_W'(HTotal - 1);
  localparam logic [CNT_W-1:0] VLast  = CNT_W'(VTotal - 1);
  localparam int unsigned HSyncStart  = H_ACTIVE + H_FP;
  localparam int unsigned HSyncEnd    = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VSyncStart  = V_ACTIVE + V_FP;
  localparam int unsigned VSyncEnd    = V_ACTIVE + V_FP + V_SYNC;

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic [31:0]      h_wide, v_wide;

  always_comb begin
    h_cnt_d = h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == HLast) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == VLast) ? '0 : v_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Window compares are done at 32 bits so sync ends at H_TOTAL cannot overflow CNT_W.
  assign h_wide = 32'(h_cnt_q);
  assign v_wide = 32'(v_cnt_q);

  vga_flags_t flags_issue, flags_dly;

  always_comb begin
    flags_issue.active = (h_wide < H_ACTIVE) && (v_wide < V_ACTIVE);
    flags_issue.hs     = (h_wide >= HSyncStart) && (h_wide < HSyncEnd);
    flags_issue.vs     = (v_wide >= VSyncStart) && (v_wide < VSyncEnd);
  end

  assign x_pos       = h_cnt_q;
  assign y_pos       = v_cnt_q;
  assign active      = flags_issue.active;
  assign line_start  = (h_cnt_q == '0);
  assign frame_start = (h_cnt_q == '0) && (v_cnt_q == '0);

  vga_delay_line #(
    .WIDTH  ($bits(vga_flags_t)),
    .DEPTH  (RD_LAT),
    .RST_VAL('0)
  ) u_flag_dly (
    .clk_i(clk),
    .rst_i(rst),
    .d_i  (flags_issue),
    .d_o  (flags_dly)
  );

  logic [COLOR_W-1:0] pix_src;

`ifdef VGA_TEST_PATTERN_EN
  logic [COLOR_W-1:0] bar_issue;
  logic               unused_rgb;

  assign bar_issue  = COLOR_W'((h_wide * 32'd8) / H_ACTIVE);
  assign unused_rgb = ^rgb_in;

  vga_delay_line #(
    .WIDTH  (COLOR_W),
    .DEPTH  (RD_LAT),
    .RST_VAL('0)
  ) u_bar_dly (
    .clk_i(clk),
    .rst_i(rst),
    .d_i  (bar_issue),
    .d_o  (pix_src)
  );
`else
  assign pix_src = rgb_in;
`endif

  logic               de_q, de_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic [COLOR_W-1:0] color_q, color_d;

  always_comb begin
    de_d    = flags_dly.active;
    color_d = flags_dly.active ? pix_src : '0;
    hsync_d = flags_dly.hs ? SYNC_POL : ~SYNC_POL;
    vsync_d = flags_dly.vs ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      de_q    <= 1'b0;
      color_q <= '0;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
    end else begin
      de_q    <= de_d;
      color_q <= color_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign de    = de_q;
  assign color = color_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;

endmodule

// File: tb/tb_vga_display_ctrl.sv
// Randomised bench: four controller instances checked every cycle against a raster model.
`timescale 1ns/1ps
module tb_vga_display_ctrl;

  typedef struct {
    int ha, hfp, hsw, hbp;
    int va, vfp, vsw, vbp;
    int lat;
    bit pol;
    int cmode; // 0: random table colour, 1: constant 3'b101
  } cfg_t;

  cfg_t c_small = '{ha:8, hfp:2, hsw:2, hbp:2, va:4, vfp:1, vsw:1, vbp:1,
                    lat:3, pol:1'b1, cmode:0};
  cfg_t c_neg   = '{ha:8, hfp:2, hsw:2, hbp:2, va:4, vfp:1, vsw:1, vbp:1,
                    lat:1, pol:1'b0, cmode:0};
  cfg_t c_zero  = '{ha:8, hfp:2, hsw:2, hbp:2, va:4, vfp:1, vsw:1, vbp:1,
                    lat:0, pol:1'b1, cmode:1};
  cfg_t c_def   = '{ha:640, hfp:16, hsw:96, hbp:48, va:480, vfp:10, vsw:2, vbp:33,
                    lat:1, pol:1'b1, cmode:0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0] rgb_small, rgb_neg, rgb_zero, rgb_def;
  logic [9:0] sm_x, sm_y, ng_x, ng_y, zr_x, zr_y, df_x, df_y;
  logic       sm_act, sm_fs, sm_ls, sm_hs, sm_vs, sm_de;
  logic       ng_act, ng_fs, ng_ls, ng_hs, ng_vs, ng_de;
  logic       zr_act, zr_fs, zr_ls, zr_hs, zr_vs, zr_de;
  logic       df_act, df_fs, df_ls, df_hs, df_vs, df_de;
  logic [2:0] sm_col, ng_col, zr_col, df_col;

  vga_display_ctrl #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1),
    .V_BP(1), .SYNC_POL(1'b1), .COLOR_W(3), .CNT_W(10), .RD_LAT(3)
  ) u_small (
    .clk(clk), .rst(rst), .rgb_in(rgb_small), .x_pos(sm_x), .y_pos(sm_y), .active(sm_act),
    .frame_start(sm_fs), .line_start(sm_ls), .hsync(sm_hs), .vsync(sm_vs), .de(sm_de),
    .color(sm_col)
  );

  vga_display_ctrl #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1),
    .V_BP(1), .SYNC_POL(1'b0), .COLOR_W(3), .CNT_W(10), .RD_LAT(1)
  ) u_neg (
    .clk(clk), .rst(rst), .rgb_in(rgb_neg), .x_pos(ng_x), .y_pos(ng_y), .active(ng_act),
    .frame_start(ng_fs), .line_start(ng_ls), .hsync(ng_hs), .vsync(ng_vs), .de(ng_de),
    .color(ng_col)
  );

  vga_display_ctrl #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1),
    .V_BP(1), .SYNC_POL(1'b1), .COLOR_W(3), .CNT_W(10), .RD_LAT(0)
  ) u_zero (
    .clk(clk), .rst(rst), .rgb_in(rgb_zero), .x_pos(zr_x), .y_pos(zr_y), .active(zr_act),
    .frame_start(zr_fs), .line_start(zr_ls), .hsync(zr_hs), .vsync(zr_vs), .de(zr_de),
    .color(zr_col)
  );

  vga_display_ctrl u_def (
    .clk(clk), .rst(rst), .rgb_in(rgb_def), .x_pos(df_x), .y_pos(df_y), .active(df_act),
    .frame_start(df_fs), .line_start(df_ls), .hsync(df_hs), .vsync(df_vs), .de(df_de),
    .color(df_col)
  );

  logic [2:0] tbl [1024];
  int chk_cnt = 0;
  int pass_cnt = 0;
  int cyc = 0;      // cycles since the last reset edge: the raster index
  int abs_cyc = 0;
  bit mid_done = 0;
  bit post_mid = 0;

  logic rt_prev [3];
  int   rt_start [3];
  bit   rt_ok [3];
  int   pd_last [2];

  task automatic chk(string name, int act, int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, abs_cyc, act, exp);
  endtask

  function automatic logic [2:0] src_color(cfg_t c, int x, int y);
`ifdef VGA_TEST_PATTERN_EN
    return 3'((x * 8) / c.ha);
`else
    if (c.cmode == 1) return 3'b101;
    return tbl[(x + 7 * y) % 1024];
`endif
  endfunction

  // Renderer stand-in: answers the coordinate issued lat cycles ago; junk before that.
  function automatic logic [2:0] drive_rgb(cfg_t c, int now);
    int ht = c.ha + c.hfp + c.hsw + c.hbp;
    int vt = c.va + c.vfp + c.vsw + c.vbp;
    int k = now - c.lat;
`ifdef VGA_TEST_PATTERN_EN
    return 3'($urandom);
`else
    if (k < 0) return 3'($urandom);
    return src_color(c, k % ht, (k / ht) % vt);
`endif
  endfunction

  task automatic check_inst(string tag, cfg_t c, logic [9:0] xp, logic [9:0] yp,
                            logic act, logic fs, logic ls, logic de, logic hs, logic vs,
                            logic [2:0] col);
    int ht = c.ha + c.hfp + c.hsw + c.hbp;
    int vt = c.va + c.vfp + c.vsw + c.vbp;
    int x = cyc % ht;
    int y = (cyc / ht) % vt;
    int k = cyc - c.lat - 1;
    logic e_de = 1'b0;
    logic e_hs = !c.pol;
    logic e_vs = !c.pol;
    logic [2:0] e_col = 3'd0;
    chk({tag, ".x_pos"}, int'(xp), x);
    chk({tag, ".y_pos"}, int'(yp), y);
    chk({tag, ".active"}, int'(act), int'(x < c.ha && y < c.va));
    chk({tag, ".frame_start"}, int'(fs), int'(x == 0 && y == 0));
    chk({tag, ".line_start"}, int'(ls), int'(x == 0));
    if (k >= 0) begin
      int kx = k % ht;
      int ky = (k / ht) % vt;
      e_de = (kx < c.ha) && (ky < c.va);
      if (kx >= c.ha + c.hfp && kx < c.ha + c.hfp + c.hsw) e_hs = c.pol;
      if (ky >= c.va + c.vfp && ky < c.va + c.vfp + c.vsw) e_vs = c.pol;
      e_col = e_de ? src_color(c, kx, ky) : 3'd0;
    end
    chk({tag, ".de"}, int'(de), int'(e_de));
    chk({tag, ".hsync"}, int'(hs), int'(e_hs));
    chk({tag, ".vsync"}, int'(vs), int'(e_vs));
    chk({tag, ".color"}, int'(col), int'(e_col));
  endtask

  // Pulse-width measurement at the pins; runs that span a reset are discarded.
  task automatic run_track(int i, logic asserted, int expw, string name);
    if (asserted && !rt_prev[i]) begin
      rt_start[i] = abs_cyc;
      rt_ok[i] = 1'b1;
    end else if (!asserted && rt_prev[i] && rt_ok[i]) begin
      chk(name, abs_cyc - rt_start[i], expw);
    end
    rt_prev[i] = asserted;
  endtask

  task automatic period_track(int i, logic strobe, int expp, string name);
    if (strobe) begin
      if (pd_last[i] >= 0) chk(name, abs_cyc - pd_last[i], expp);
      pd_last[i] = abs_cyc;
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) tbl[i] = 3'($urandom);
    for (int i = 0; i < 3; i++) begin
      rt_prev[i] = 1'b0;
      rt_start[i] = 0;
      rt_ok[i] = 1'b0;
    end
    pd_last[0] = -1;
    pd_last[1] = -1;
    rgb_small = '0;
    rgb_neg = '0;
    rgb_zero = 3'b101;
    rgb_def = '0;

    for (int it = 0; it < 4000; it++) begin
      @(posedge clk);
      abs_cyc++;
      if (rst) cyc = 0;
      else cyc++;
      #1;
      if (it < 3) begin
        rst = 1'b1;
      end else if (!mid_done && cyc == 98 + 33) begin
        // small raster sits at x=5, y=2 of its second frame
        rst = 1'b1;
        mid_done = 1'b1;
        post_mid = 1'b1;
      end else begin
        rst = 1'b0;
      end
      rgb_small = drive_rgb(c_small, cyc);
      rgb_neg   = drive_rgb(c_neg, cyc);
      rgb_zero  = drive_rgb(c_zero, cyc);
      rgb_def   = drive_rgb(c_def, cyc);

      @(negedge clk);
      check_inst("small", c_small, sm_x, sm_y, sm_act, sm_fs, sm_ls, sm_de, sm_hs, sm_vs,
                 sm_col);
      check_inst("neg", c_neg, ng_x, ng_y, ng_act, ng_fs, ng_ls, ng_de, ng_hs, ng_vs, ng_col);
      check_inst("zero", c_zero, zr_x, zr_y, zr_act, zr_fs, zr_ls, zr_de, zr_hs, zr_vs,
                 zr_col);
      check_inst("def", c_def, df_x, df_y, df_act, df_fs, df_ls, df_de, df_hs, df_vs, df_col);

      // Literal expectations pinning the model.
      if (it < 3) begin
        chk("neg_hsync_in_reset", int'(ng_hs), 1);
        chk("neg_vsync_in_reset", int'(ng_vs), 1);
      end
      if (!rst && cyc == 0) begin
        chk("small_fs_after_reset", int'(sm_fs), 1);
        chk("small_hsync_idle", int'(sm_hs), 0);
        chk("neg_hsync_idle", int'(ng_hs), 1);
        chk("neg_vsync_idle", int'(ng_vs), 1);
      end
      if (post_mid && !rst) begin
        if (cyc <= 3) begin
          chk("midrst_de_blank", int'(sm_de), 0);
          chk("midrst_color_blank", int'(sm_col), 0);
          chk("midrst_hsync_idle", int'(sm_hs), 0);
          if (cyc == 0) begin
            chk("midrst_x0", int'(sm_x), 0);
            chk("midrst_y0", int'(sm_y), 0);
            chk("midrst_fs", int'(sm_fs), 1);
          end
        end else begin
          post_mid = 1'b0;
        end
      end
`ifdef VGA_TEST_PATTERN_EN
      if (!rst && cyc == 42) chk("bar_x40", int'(df_col), 0);
      if (!rst && cyc == 602) chk("bar_x600", int'(df_col), 7);
`else
      if (!rst && cyc == 1) chk("zero_lat_first_active", int'(zr_col), 5);
      if (!rst && cyc == 9) chk("zero_lat_first_blank", int'(zr_col), 0);
`endif

      run_track(0, sm_vs == 1'b1, 14, "small_vsync_width");
      run_track(1, ng_hs == 1'b0, 2, "neg_hsync_width");
      run_track(2, df_hs == 1'b1, 96, "def_hsync_width");
      period_track(0, sm_fs, 98, "small_frame_period");
      period_track(1, df_ls, 800, "def_line_period");
      if (rst) begin
        for (int i = 0; i < 3; i++) rt_ok[i] = 1'b0;
        pd_last[0] = -1;
        pd_last[1] = -1;
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/vga_display_ctrl.md
# vga_display_ctrl

Parametrised VGA timing and pixel-output controller: one counter pipeline generates raster coordinates, fetches colour from the renderer with a configurable read latency, and drives sync, data-enable and blanked colour, all aligned at the pins. Sits between the pixel-clock domain and the game renderer. Supersedes the fixed 640x480 counter/colour pair, and adds arbitrary timing, programmable sync polarity, renderer latency compensation and frame/line strobes.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in pixels
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines
- SYNC_POL, 1'b1, active level of hsync/vsync (1 = active high)
- COLOR_W, 3, colour width
- CNT_W, 10, coordinate width; H_TOTAL-1 and V_TOTAL-1 must fit
- RD_LAT, 1, cycles from x_pos/y_pos to matching rgb_in (0..7)
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- rgb_in  in  COLOR_W  renderer colour for the coordinate issued RD_LAT cycles earlier
- x_pos, y_pos  out  CNT_W  raster coordinate being requested (raw counters)
- active  out  1  x_pos/y_pos lie in the visible area
- frame_start  out  1  one-cycle strobe when x_pos=0, y_pos=0
- line_start  out  1  one-cycle strobe when x_pos=0
- hsync, vsync  out  1  sync at the pins, level per SYNC_POL
- de  out  1  data enable at the pins
- color  out  COLOR_W  pixel colour at the pins, 0 when de=0

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is defined the same way from the vertical parameters.
- h_cnt runs 0..H_TOTAL-1 and wraps to 0. On that wrap, v_cnt increments and wraps from V_TOTAL-1 to 0.
- x_pos/y_pos are the h_cnt/v_cnt registers, driven directly.
- active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE). It is combinational from the counters.
- frame_start and line_start are combinational from the counters.
- Sync windows:
  - hsync is asserted for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync is asserted for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, for every h_cnt.
- Alignment pipeline:
  - A RD_LAT-deep shift register carries {active, hsync_raw, vsync_raw} with each issued coordinate.
  - In the cycle that delayed flags arrive, rgb_in is sampled.
  - Output registers take de = active_d, color = active_d ? rgb_in : 0, and hsync/vsync = raw_d ? SYNC_POL : ~SYNC_POL.
  - With RD_LAT=0, rgb_in is combinationally matched to the current x_pos/y_pos.
- Reset:
  - h_cnt = v_cnt = 0 and all pipeline stages are cleared to inactive.
  - Output reset values: color=0, de=0, hsync=vsync=~SYNC_POL.
  - x_pos=y_pos=0, so active=1, frame_start=1 and line_start=1 in the first cycle after reset.
  - Reset mid-frame aborts the frame. The next frame starts cleanly at (0,0) with no partial sync pulse, because the pipeline is flushed.
- rgb_in bits are passed through unmodified. No arithmetic is applied to colour.

## Timing
- Pin latency is RD_LAT+1 cycles from a coordinate on x_pos/y_pos to its hsync/vsync/de/color.
- Sync, de and colour are always mutually aligned, for every RD_LAT.
- The first RD_LAT+1 cycles after reset release drive blank outputs with sync inactive.
- Wrap at (H_TOTAL-1, V_TOTAL-1): the next cycle is (0,0) with frame_start=1. There is no idle cycle.
- Sync pulse lengths at the pins are exactly H_SYNC clocks and V_SYNC*H_TOTAL clocks.
- Frame period is exactly H_TOTAL*V_TOTAL clocks.

## Configuration
- VGA_TEST_PATTERN_EN defined:
  - rgb_in is ignored.
  - Colour is replaced by eight vertical bars, value = floor(x*8/H_ACTIVE) truncated to COLOR_W, computed on the issued coordinate and delayed through the same pipeline.
  - Timing and latency are unchanged.
- Not defined: colour comes from rgb_in as specified above.

## Structure
- Shared package vga_pkg holds:
  - a typedef for a coordinate (logic [CNT_W-1:0]) and for colour;
  - a struct for the pipeline flags {active, hs, vs};
  - default 640x480@60 timing constants.
- One sub-module, vga_delay_line, is a parametrised shift register (WIDTH, DEPTH, reset value) used for the flag pipeline and the test-pattern colour.

## Test plan
- Default parameters, run one full frame:
  - exactly 800*525 = 420000 clocks between frame_start pulses;
  - hsync high for exactly 96 clocks per line;
  - vsync high for exactly 2*800 = 1600 clocks.
- H_ACTIVE=8, H_FP=H_SYNC=H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1, RD_LAT=3, rgb_in = x_pos[2:0] fed through a 3-stage model:
  - color at the pins equals x 4 cycles after issue for x=0..7;
  - color=0 and de=0 for x>=8.
- SYNC_POL=0 with the small timing above:
  - hsync idles 1 and pulses 0 for 2 clocks;
  - both syncs read 1 during and right after reset.
- Assert rst at h_cnt=5, v_cnt=2 for 1 cycle:
  - the next cycle shows x_pos=0, y_pos=0, frame_start=1;
  - de/color/syncs stay inactive for RD_LAT+1 cycles.
- RD_LAT=0 with rgb_in tied to 3'b101:
  - color=101 exactly 1 cycle after each active coordinate;
  - color=000 1 cycle after the first blank coordinate.
- VGA_TEST_PATTERN_EN defined, default timing:
  - x=0..79 yields colour 0 and x=560..639 yields colour 7;
  - rgb_in toggling has no effect.
